// File: rtl/mac_serial_seq.sv
// mac_serial_seq: multi-lane multibit-serial MAC with runtime precision and built-in accumulation controller
module mac_serial_seq #(
  parameter int W_WIDTH    = 8,
  parameter int A_WIDTH    = 8,
  parameter int N_WIDTH    = 2,
  parameter int PLUS_WIDTH = 4,
  parameter int LANES      = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int Z_WIDTH   = W_WIDTH + A_WIDTH + PLUS_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 cfg_w_prec,
  input  logic                       cfg_a_signed,
  input  logic [CNT_WIDTH-1:0]       cfg_acc_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*W_WIDTH-1:0]   w,
  input  logic [LANES*A_WIDTH-1:0]   a,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*Z_WIDTH-1:0]   z
);
  localparam int P_WIDTH = W_WIDTH + A_WIDTH;
  localparam int S_WIDTH = $clog2(W_WIDTH / N_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, ACC, OUT} state_t;
  state_t state, next_state;
  logic [1:0] prec;
  logic a_signed;
  logic [CNT_WIDTH-1:0] acc_len, op_cnt;
  logic [S_WIDTH-1:0] step, steps;
  logic accept, last, done;
  assign steps = S_WIDTH'((W_WIDTH >> prec) / N_WIDTH);
  assign last = step == steps - S_WIDTH'(1);
  assign done = op_cnt + CNT_WIDTH'(1) == acc_len;
  assign accept = in_valid & in_ready;
  always_comb begin
    next_state = state;
    in_ready = state == IDLE;
    out_valid = state == OUT;
    unique case (state)
      IDLE:  next_state = in_valid ? SHIFT : IDLE;
      SHIFT: next_state = last ? ACC : SHIFT;
      ACC:   next_state = done ? OUT : IDLE;
      OUT:   next_state = out_ready ? IDLE : OUT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step <= '0;
      op_cnt <= '0;
      prec <= 2'd0;
      a_signed <= 1'b0;
      acc_len <= CNT_WIDTH'(1);
    end else begin
      state <= next_state;
      if (accept) begin
        step <= '0;
        if (op_cnt == '0) begin
          prec <= cfg_w_prec == 2'd3 ? 2'd0 : cfg_w_prec;
          a_signed <= cfg_a_signed;
          acc_len <= cfg_acc_len == '0 ? CNT_WIDTH'(1) : cfg_acc_len;
        end
      end
      if (state == SHIFT) step <= step + S_WIDTH'(1);
      if (state == ACC) op_cnt <= op_cnt + CNT_WIDTH'(1);
      if (state == OUT && out_ready) op_cnt <= '0;
    end
  end
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [W_WIDTH-1:0] w_q;
    logic [A_WIDTH-1:0] a_q;
    logic [P_WIDTH-1:0] prod;
    logic [Z_WIDTH-1:0] z_acc, a_ext, prod_ext, pp, prod_next;
    assign a_ext = {{(Z_WIDTH-A_WIDTH){a_signed & a_q[A_WIDTH-1]}}, a_q};
    assign prod_ext = {{PLUS_WIDTH{prod[P_WIDTH-1]}}, prod};
    // the top weight bit of the final chunk carries negative weight
    always_comb begin
      pp = '0;
      for (int j = 0; j < N_WIDTH; j++)
        if (w_q[j]) pp = (last && j == N_WIDTH - 1) ? pp - (a_ext << j) : pp + (a_ext << j);
      prod_next = prod_ext + (pp << (step * N_WIDTH));
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        w_q <= '0;
        a_q <= '0;
        prod <= '0;
        z_acc <= '0;
      end else begin
        if (accept) begin
          w_q <= w[l*W_WIDTH +: W_WIDTH];
          a_q <= a[l*A_WIDTH +: A_WIDTH];
          prod <= '0;
        end
        if (state == SHIFT) begin
          prod <= prod_next[P_WIDTH-1:0];
          w_q <= w_q >> N_WIDTH;
        end
        if (state == ACC) z_acc <= z_acc + prod_ext;
        if (state == OUT && out_ready) z_acc <= '0;
      end
    end
    assign z[l*Z_WIDTH +: Z_WIDTH] = z_acc;
  end
endmodule

// File: tb/tb_mac_serial_seq.sv
// tb_mac_serial_seq: scoreboard bench for mac_serial_seq, one task per scenario
module tb_mac_serial_seq;
  localparam int L = 4;
  localparam int ZW = 20;
  logic clk = 0, rst = 0;
  logic [1:0] cfg_w_prec = 0;
  logic cfg_a_signed = 0;
  logic [15:0] cfg_acc_len = 1;
  logic in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [L*8-1:0] w = 0, a = 0;
  logic [L*ZW-1:0] z, exp_z;
  logic [ZW-1:0] m_acc [L];
  int m_p, m_n, m_k, pass_cnt = 0, tot_cnt = 0;
  bit m_sgn;
  logic [L*ZW-1:0] sb [$];

  mac_serial_seq dut (
    .clk(clk), .rst(rst), .cfg_w_prec(cfg_w_prec), .cfg_a_signed(cfg_a_signed),
    .cfg_acc_len(cfg_acc_len), .in_valid(in_valid), .in_ready(in_ready), .w(w), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .z(z)
  );

  always #5 clk = ~clk;

  function automatic logic [ZW-1:0] prod_m(logic [7:0] wv, logic [7:0] av, int p, bit sg);
    longint ws, as;
    ws = longint'(wv) & ((longint'(1) << p) - 1);
    if (ws >= (longint'(1) << (p - 1))) ws -= longint'(1) << p;
    as = sg ? longint'($signed(av)) : longint'(av);
    return ZW'(ws * as);
  endfunction

  task automatic model_clear();
    for (int l = 0; l < L; l++) m_acc[l] = '0;
    m_n = 0;
  endtask

  task automatic set_cfg(input int pr, input bit sg, input int k);
    cfg_w_prec = 2'(pr);
    cfg_a_signed = sg;
    cfg_acc_len = 16'(k);
    m_p = pr == 3 ? 8 : 8 >> pr;
    m_sgn = sg;
    m_k = k == 0 ? 1 : k;
  endtask

  task automatic send(input logic [L*8-1:0] wv, input logic [L*8-1:0] av);
    int n = 0;
    w = wv; a = av; in_valid = 1;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    tot_cnt++;
    if (!in_ready) $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 0;
    for (int l = 0; l < L; l++) m_acc[l] = m_acc[l] + prod_m(wv[l*8 +: 8], av[l*8 +: 8], m_p, m_sgn);
    m_n++;
    if (m_n == m_k) begin
      for (int l = 0; l < L; l++) exp_z[l*ZW +: ZW] = m_acc[l];
      sb.push_back(exp_z);
      model_clear();
    end
  endtask

  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
    exp_z = sb.size() > 0 ? sb.pop_front() : 'x;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_clear();
    tot_cnt += 3;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b required 1", in_ready); else pass_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b required 0", out_valid); else pass_cnt++;
    if (z !== '0) $display("FAIL reset_z: got %h required 0", z); else pass_cnt++;
  endtask

  task automatic test_prec8();
    int cyc = 1;
    bit ir_bad = 0;
    set_cfg(0, 0, 1);
    send({8'h7F, 8'h01, 8'h80, 8'hFD}, {8'd255, 8'd9, 8'd3, 8'd200});
    while (!out_valid && cyc < 200) begin
      if (in_ready) ir_bad = 1;
      @(posedge clk); #1; cyc++;
    end
    exp_z = sb.pop_front();
    tot_cnt += 5;
    if (cyc !== 6) $display("FAIL p8_latency: got %0d cycles required 6", cyc); else pass_cnt++;
    if (ir_bad || in_ready !== 1'b0) $display("FAIL p8_in_ready_busy: got high required low"); else pass_cnt++;
    if (z[ZW-1:0] !== ZW'(-600)) $display("FAIL p8_lane0: got %0d required -600", $signed(z[ZW-1:0])); else pass_cnt++;
    if (z !== exp_z) $display("FAIL p8_z: got %h required %h", z, exp_z); else pass_cnt++;
    @(posedge clk); #1;
    if (out_valid !== 1'b0) $display("FAIL p8_out_drop: got %0b required 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_prec4();
    int cyc = 1;
    set_cfg(1, 0, 2);
    send({8'h12, 8'h05, 8'h37, 8'h0A}, {8'd7, 8'd100, 8'd10, 8'd250});
    while (!in_ready && cyc < 200) begin @(posedge clk); #1; cyc++; end
    tot_cnt++;
    if (cyc !== 4) $display("FAIL p4_op_cycles: got %0d required 4", cyc); else pass_cnt++;
    cfg_w_prec = 2'd0;
    send({8'h9C, 8'hF8, 8'h0F, 8'h03}, {8'd33, 8'd1, 8'd10, 8'd77});
    wait_out(cyc);
    tot_cnt += 3;
    if (cyc !== 4) $display("FAIL p4_latency: got %0d required 4", cyc); else pass_cnt++;
    if (z[ZW +: ZW] !== ZW'(60)) $display("FAIL p4_lane1: got %0d required 60", $signed(z[ZW +: ZW])); else pass_cnt++;
    if (z !== exp_z) $display("FAIL p4_z: got %h required %h", z, exp_z); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_prec2();
    int cyc;
    for (int s = 1; s >= 0; s--) begin
      set_cfg(2, s[0], 1);
      send({4{8'h02}}, {4{8'h80}});
      wait_out(cyc);
      tot_cnt += 3;
      if (cyc !== 3) $display("FAIL p2_latency: got %0d required 3", cyc); else pass_cnt++;
      if (z[ZW-1:0] !== (s ? ZW'(256) : ZW'(-256)))
        $display("FAIL p2_lane0_sgn%0d: got %0d required %0d", s, $signed(z[ZW-1:0]), s ? 256 : -256);
      else pass_cnt++;
      if (z !== exp_z) $display("FAIL p2_z: got %h required %h", z, exp_z); else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    int cyc;
    set_cfg(0, 0, 17);
    repeat (17) send({4{8'h80}}, {4{8'hFF}});
    wait_out(cyc);
    tot_cnt += 2;
    if (z !== {4{ZW'(493696)}}) $display("FAIL wrap_lanes: got %h required %h", z, {4{ZW'(493696)}}); else pass_cnt++;
    if (z !== exp_z) $display("FAIL wrap_z: got %h required %h", z, exp_z); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [L*ZW-1:0] snap;
    bit bad = 0;
    out_ready = 0;
    set_cfg(0, 1, 1);
    send({8'h91, 8'h2E, 8'hC3, 8'h45}, {8'hA7, 8'h19, 8'hF0, 8'h6B});
    wait_out(cyc);
    snap = z;
    tot_cnt += 2;
    if (z !== exp_z) $display("FAIL bp_z: got %h required %h", z, exp_z); else pass_cnt++;
    in_valid = 1;
    w = {4{8'h01}}; a = {4{8'h05}};
    set_cfg(0, 0, 1);
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || z !== snap || in_ready !== 1'b0) bad = 1;
    end
    if (bad) $display("FAIL bp_hold: out_valid=%0b in_ready=%0b z=%h required 1/0/%h", out_valid, in_ready, z, snap);
    else pass_cnt++;
    out_ready = 1;
    send({4{8'h01}}, {4{8'h05}});
    wait_out(cyc);
    tot_cnt += 2;
    if (z !== {4{ZW'(5)}}) $display("FAIL bp_next: got %h required %h", z, {4{ZW'(5)}}); else pass_cnt++;
    if (z !== exp_z) $display("FAIL bp_next_z: got %h required %h", z, exp_z); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen = 0;
    set_cfg(0, 0, 1);
    send({4{8'h7B}}, {4{8'hC8}});
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    sb.delete();
    model_clear();
    tot_cnt += 4;
    if (in_ready !== 1'b1) $display("FAIL rm_in_ready: got %0b required 1", in_ready); else pass_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rm_out_valid: got %0b required 0", out_valid); else pass_cnt++;
    if (z !== '0) $display("FAIL rm_z: got %h required 0", z); else pass_cnt++;
    repeat (8) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    if (seen) $display("FAIL rm_ghost_out: got out_valid=1 required 0"); else pass_cnt++;
    set_cfg(0, 0, 1);
    send({4{8'h02}}, {4{8'h03}});
    wait_out(cyc);
    tot_cnt += 2;
    if (z !== {4{ZW'(6)}}) $display("FAIL rm_fresh: got %h required %h", z, {4{ZW'(6)}}); else pass_cnt++;
    if (z !== exp_z) $display("FAIL rm_fresh_z: got %h required %h", z, exp_z); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc, pr;
    for (int i = 0; i < 6; i++) begin
      pr = $urandom_range(0, 3);
      set_cfg(pr, 1'($urandom_range(0, 1)), 0);
      send($urandom, $urandom);
      wait_out(cyc);
      tot_cnt += 2;
      if (cyc !== m_p / 2 + 2) $display("FAIL b2b_latency%0d: got %0d required %0d", i, cyc, m_p / 2 + 2); else pass_cnt++;
      if (z !== exp_z) $display("FAIL b2b_z%0d: got %h required %h", i, z, exp_z); else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_prec8();
    test_prec4();
    test_prec2();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
